aes_job_dispatcher: RTL and testbench
=====================================

Name: aes_job_dispatcher

Overview:
- Upstream feeder for aes_engine. Accepts encrypt/decrypt jobs and key updates from the host-side valid/ready interface, and buffers jobs in a small FIFO.
- Sequences the engine's key load: a set_key pulse followed by a key-expansion wait.
- Issues at most one job per cycle into the engine's in_type/state inputs, and converts host halt requests into an engine halt pulse plus a FIFO flush.

Parameters:
- FIFO_DEPTH, 4, job FIFO entries (power of two, ≥2).
- KEY_WAIT, 10, cycles after the eng_set_key pulse before the first job may issue.
- PIPE_DEPTH, 10, drain cycles with no issue before a key change while running.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  host job valid
- job_ready  out  1  job accepted when valid&&ready
- job_type  in  job_t  ENCRYPT/DECRYPT; INVALID jobs are consumed and dropped
- job_data  in  128  plaintext/ciphertext block
- key_valid  in  1  host key valid
- key_ready  out  1  key accepted when valid&&ready
- key_in  in  128  AES-128 key
- halt_req  in  1  abort request (level; sampled each cycle)
- eng_in_type  out  job_t  to aes_engine.in_type
- eng_state  out  128  to aes_engine.state
- eng_set_key  out  1  to aes_engine.set_key
- eng_key  out  128  to aes_engine.key
- eng_halt  out  1  to aes_engine.halt
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- key_loaded  out  1  a valid expanded key is present in the engine

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - FSM = IDLE
  - eng_in_type = INVALID
  - eng_state = 0, eng_key = 0
  - eng_set_key = 0, eng_halt = 0
  - fifo_count = 0, key_loaded = 0
  - FIFO pointers = 0
- All eng_* outputs are registered.
- FIFO:
  - job_ready = !full && !halt_req.
  - INVALID-type handshakes complete but are not written.
  - No push-when-full bypass. Push and pop in the same cycle keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, KEYSET, KEYWAIT, RUN, DRAIN.
  - IDLE: key_ready=1. Jobs may be buffered but none issue. key_valid → latch eng_key=key_in → KEYSET.
  - KEYSET: eng_set_key=1 for exactly one cycle; key_loaded←0; key_ready=0 → KEYWAIT, counter←KEY_WAIT-1.
  - KEYWAIT: counter decrements to 0 → RUN, key_loaded←1. No issue.
  - RUN:
    - If FIFO non-empty, pop head; next cycle eng_in_type=head.type and eng_state=head.data.
    - Otherwise eng_in_type=INVALID and eng_state holds its last value.
    - key_ready=1. key_valid → latch key, stop issuing, → DRAIN with counter←PIPE_DEPTH-1.
  - DRAIN: no issue (eng_in_type=INVALID). Counter reaches 0 → KEYSET.
- Latency: a job accepted in cycle N with the FIFO empty in RUN appears on eng_in_type in cycle N+2. Throughput is 1 job/cycle sustained.
- eng_in_type is INVALID in every cycle without an issue. Each job issues exactly once, in FIFO order.
- Halt:
  - halt_req=1 in any state → eng_halt=1 next cycle (one-cycle pulse per rising edge of halt_req).
  - FIFO is flushed (count←0). The issue in that cycle is suppressed.
  - Halt during KEYSET/KEYWAIT/DRAIN: key load aborted, key_loaded←0 → IDLE.
  - Halt in RUN: stays in RUN, key retained.
  - Halt in IDLE: flush only.
- Simultaneous events:
  - halt_req has priority over key_valid and job pop. key_ready=0 while halt_req=1.
  - A key_valid in the same cycle a pop occurs in RUN: the pop completes, and DRAIN starts the following cycle.
- Reset mid-operation: immediate return to reset values. In-flight FIFO content is discarded.

Test Plan:
- Key load: key_in=000102030405060708090a0b0c0d0e0f in IDLE.
  - Required: eng_set_key high exactly 1 cycle.
  - key_loaded rises after 10 KEYWAIT cycles.
  - eng_key holds the key throughout.
- Single encrypt: after key load, push ENCRYPT/00112233445566778899aabbccddeeff.
  - Required: eng_in_type=ENCRYPT with that state 2 cycles after the handshake, INVALID the cycle before and after.
  - With aes_engine attached: out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: with FIFO_DEPTH=4, push 5 jobs while in IDLE.
  - Required: job_ready drops at count=4, and the 5th job stalls.
  - After key load, 4 jobs issue on consecutive cycles in order, then the 5th.
- Key change in RUN: 2 jobs queued, key_valid asserted.
  - Required: 10 INVALID cycles, then a set_key pulse, then 10 wait cycles, then the queued jobs issue.
- Halt: 3 jobs queued in RUN, halt_req for 1 cycle.
  - Required: eng_halt pulse of 1 cycle, fifo_count=0, no further issues, key_loaded stays 1.
  - Repeat during KEYWAIT → IDLE and key_loaded=0.
- Reset mid-stream: assert rst_n=0 asynchronously during RUN with 2 jobs queued.
  - Required: all outputs at reset values immediately, and no issue after reset release until a new key load.

Source files
------------

// File: rtl/aes_job_dispatcher.sv
// aes_job_dispatcher: host-side feeder for aes_engine. Buffers encrypt/decrypt
// jobs in a small FIFO, sequences key loads and turns halt requests into flushes.
// Ports: clk/rst_n; job_valid/job_ready/job_type/job_data (job stream);
// key_valid/key_ready/key_in (key stream); halt_req (abort level);
// eng_in_type/eng_state/eng_set_key/eng_key/eng_halt (registered engine drive);
// fifo_count (occupancy); key_loaded (engine holds a valid expanded key).

package aes_job_pkg;
    typedef enum logic [1:0] {
        INVALID = 2'b00,
        ENCRYPT = 2'b01,
        DECRYPT = 2'b10
    } job_t;
endpackage

module aes_job_dispatcher
    import aes_job_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_WAIT   = 10,
    parameter int PIPE_DEPTH = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  job_t                          job_type,
    input  logic [127:0]                  job_data,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [127:0]                  key_in,
    input  logic                          halt_req,
    output job_t                          eng_in_type,
    output logic [127:0]                  eng_state,
    output logic                          eng_set_key,
    output logic [127:0]                  eng_key,
    output logic                          eng_halt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          key_loaded
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (KEY_WAIT > PIPE_DEPTH) ? KEY_WAIT : PIPE_DEPTH;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        KEYSET,
        KEYWAIT,
        RUN,
        DRAIN
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    job_t           fifo_type [FIFO_DEPTH];
    logic [127:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           halt_q;
    logic           full, empty, push, pop, key_take;

    assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign empty     = fifo_count == '0;
    assign job_ready = !full && !halt_req;
    assign key_ready = (state == IDLE || state == RUN) && !halt_req;
    // INVALID jobs complete the handshake but never reach the FIFO.
    assign push      = job_valid && job_ready && (job_type != INVALID);
    assign pop       = (state == RUN) && !empty && !halt_req;
    assign key_take  = key_valid && key_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (halt_req) begin
            // A halt aborts any key load in progress; RUN keeps its key.
            if (state == KEYSET || state == KEYWAIT || state == DRAIN) begin
                state_nx = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) state_nx = KEYSET;
                end
                KEYSET: begin
                    state_nx = KEYWAIT;
                    cnt_nx   = CW'(KEY_WAIT - 1);
                end
                KEYWAIT: begin
                    if (cnt == '0) state_nx = RUN;
                    else cnt_nx = cnt - CW'(1);
                end
                RUN: begin
                    if (key_valid) begin
                        state_nx = DRAIN;
                        cnt_nx   = CW'(PIPE_DEPTH - 1);
                    end
                end
                DRAIN: begin
                    if (cnt == '0) state_nx = KEYSET;
                    else cnt_nx = cnt - CW'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_type[wr_ptr] <= job_type;
            fifo_data[wr_ptr] <= job_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (halt_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_in_type <= INVALID;
            eng_state   <= '0;
            eng_set_key <= 1'b0;
            eng_key     <= '0;
            eng_halt    <= 1'b0;
            halt_q      <= 1'b0;
            key_loaded  <= 1'b0;
        end else begin
            halt_q      <= halt_req;
            eng_halt    <= halt_req && !halt_q;
            // Registered so the pulse lines up with the KEYSET cycle itself.
            eng_set_key <= (state_nx == KEYSET);
            eng_in_type <= pop ? fifo_type[rd_ptr] : INVALID;
            if (pop) eng_state <= fifo_data[rd_ptr];
            if (key_take) eng_key <= key_in;
            if (halt_req) begin
                if (state == KEYSET || state == KEYWAIT || state == DRAIN) begin
                    key_loaded <= 1'b0;
                end
            end else if (state == KEYSET) begin
                key_loaded <= 1'b0;
            end else if (state == KEYWAIT && cnt == '0) begin
                key_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_dispatcher.sv
// Self-checking bench for aes_job_dispatcher: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_aes_job_dispatcher;
    import aes_job_pkg::*;

    localparam int DEPTH = 4;
    localparam int KW    = 10;
    localparam int PD    = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    job_t         job_type = INVALID;
    logic [127:0] job_data = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         halt_req = 1'b0;
    job_t         eng_in_type;
    logic [127:0] eng_state;
    logic         eng_set_key;
    logic [127:0] eng_key;
    logic         eng_halt;
    logic [2:0]   fifo_count;
    logic         key_loaded;

    int n_checks = 0;
    int n_errors = 0;

    aes_job_dispatcher #(
        .FIFO_DEPTH(DEPTH),
        .KEY_WAIT(KW),
        .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_type(job_type),
        .job_data(job_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_in(key_in),
        .halt_req(halt_req),
        .eng_in_type(eng_in_type),
        .eng_state(eng_state),
        .eng_set_key(eng_set_key),
        .eng_key(eng_key),
        .eng_halt(eng_halt),
        .fifo_count(fifo_count),
        .key_loaded(key_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        job_t         t;
        logic [127:0] d;
    } mjob_t;

    localparam int PH_IDLE = 0, PH_KEYSET = 1, PH_KEYWAIT = 2;
    localparam int PH_RUN = 3, PH_DRAIN = 4;

    mjob_t        mq[$];
    mjob_t        mj;
    int           m_phase = PH_IDLE;
    int           m_left = 0;
    bit           m_jr, m_kr;
    bit           m_hprev = 1'b0;
    job_t         e_type = INVALID;
    logic [127:0] e_state = '0;
    logic [127:0] e_key = '0;
    logic         e_set_key = 1'b0;
    logic         e_halt = 1'b0;
    logic         e_loaded = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase   = PH_IDLE;
            m_left    = 0;
            m_hprev   = 1'b0;
            e_type    = INVALID;
            e_state   = '0;
            e_key     = '0;
            e_set_key = 1'b0;
            e_halt    = 1'b0;
            e_loaded  = 1'b0;
        end else begin
            m_jr = (mq.size() < DEPTH) && !halt_req;
            m_kr = (m_phase == PH_IDLE || m_phase == PH_RUN) && !halt_req;
            e_halt = halt_req && !m_hprev;
            m_hprev = halt_req;
            e_type = INVALID;
            e_set_key = 1'b0;
            if (halt_req) begin
                mq.delete();
                if (m_phase != PH_RUN) begin
                    m_phase  = PH_IDLE;
                    e_loaded = 1'b0;
                end
            end else begin
                if (m_phase == PH_RUN && mq.size() > 0) begin
                    mj = mq.pop_front();
                    e_type = mj.t;
                    e_state = mj.d;
                end
                if (key_valid && m_kr) e_key = key_in;
                case (m_phase)
                    PH_IDLE: if (key_valid) begin
                        m_phase = PH_KEYSET;
                        e_set_key = 1'b1;
                    end
                    PH_KEYSET: begin
                        e_loaded = 1'b0;
                        m_phase = PH_KEYWAIT;
                        m_left = KW;
                    end
                    PH_KEYWAIT: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_RUN;
                            e_loaded = 1'b1;
                        end
                    end
                    PH_RUN: if (key_valid) begin
                        m_phase = PH_DRAIN;
                        m_left = PD;
                    end
                    default: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_KEYSET;
                            e_set_key = 1'b1;
                        end
                    end
                endcase
                if (job_valid && m_jr && job_type != INVALID)
                    mq.push_back('{job_type, job_data});
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("cyc_in_type", eng_in_type, e_type);
        chk("cyc_state", eng_state, e_state);
        chk("cyc_set_key", eng_set_key, e_set_key);
        chk("cyc_key", eng_key, e_key);
        chk("cyc_halt", eng_halt, e_halt);
        chk("cyc_loaded", key_loaded, e_loaded);
        chk("cyc_count", fifo_count, mq.size());
        chk("cyc_job_ready", job_ready, (mq.size() < DEPTH) && !halt_req);
        chk("cyc_key_ready", key_ready,
            (m_phase == PH_IDLE || m_phase == PH_RUN) && !halt_req);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_setkey(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (!eng_set_key && n < 40);
        chk(nm, eng_set_key, 1'b1);
    endtask

    task automatic wait_loaded(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (!key_loaded && n < 40);
        chk(nm, key_loaded, 1'b1);
    endtask

    int           sk, skidx, bad;
    int           ic[$];
    job_t         it[$];
    logic [127:0] id[$];
    logic         drop;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_type", eng_in_type, INVALID);
        chk("rst_state", eng_state, 0);
        chk("rst_key", eng_key, 0);
        chk("rst_set_key", eng_set_key, 0);
        chk("rst_halt", eng_halt, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_loaded", key_loaded, 0);
        @(negedge clk) rst_n = 1'b1;

        // Key load from IDLE
        @(negedge clk);
        key_valid = 1'b1;
        key_in = K1;
        sk = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            key_in = 128'hdeadbeef;
            #2;
            if (eng_set_key) sk++;
            if (i == 1) chk("key_setkey_first", eng_set_key, 1'b1);
            if (i == 11) chk("key_loaded_early", key_loaded, 1'b0);
            if (i == 12) chk("key_loaded_rise", key_loaded, 1'b1);
            if (i == 12) chk("key_held", eng_key, K1);
        end
        chk("key_pulses", sk, 1);

        // Single encrypt, latency 2
        @(negedge clk);
        job_valid = 1'b1;
        job_type = ENCRYPT;
        job_data = P1;
        @(negedge clk);
        job_valid = 1'b0;
        #2 chk("enc_before", eng_in_type, INVALID);
        @(negedge clk);
        #2 chk("enc_type", eng_in_type, ENCRYPT);
        chk("enc_data", eng_state, P1);
        @(negedge clk);
        #2 chk("enc_after", eng_in_type, INVALID);
        chk("enc_hold", eng_state, P1);

        // Key change in RUN with two jobs queued around it
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 128'h11;
        job_valid = 1'b1;
        job_type = DECRYPT;
        job_data = 128'ha1;
        sk = 0;
        skidx = -1;
        ic.delete(); it.delete(); id.delete();
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            if (i == 1) begin
                key_valid = 1'b0;
                job_type = ENCRYPT;
                job_data = 128'ha2;
            end
            if (i == 2) job_valid = 1'b0;
            #2;
            if (eng_set_key) begin sk++; skidx = i; end
            if (eng_in_type != INVALID) begin
                ic.push_back(i); it.push_back(eng_in_type);
                id.push_back(eng_state);
            end
        end
        chk("kc_pulses", sk, 1);
        chk("kc_pulse_at", skidx, 11);
        chk("kc_issues", ic.size(), 2);
        if (ic.size() >= 2) begin
            chk("kc_first_at", ic[0], 23);
            chk("kc_second_at", ic[1], 24);
            chk("kc_first_type", it[0], DECRYPT);
            chk("kc_second_data", id[1], 128'ha2);
        end
        chk("kc_key", eng_key, 128'h11);

        // Halt in RUN with three jobs queued
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 128'h22;
        @(negedge clk);
        key_valid = 1'b0;
        job_valid = 1'b1;
        job_type = ENCRYPT;
        job_data = 128'hb0;
        @(negedge clk) job_data = 128'hb1;
        @(negedge clk) begin job_type = DECRYPT; job_data = 128'hb2; end
        @(negedge clk) job_valid = 1'b0;
        wait_setkey("hr_setkey_seen");
        wait_loaded("hr_loaded_seen");
        chk("hr_count_before", fifo_count, 3);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        #2 chk("hr_halt_pulse", eng_halt, 1'b1);
        chk("hr_count_flushed", fifo_count, 0);
        chk("hr_no_issue", eng_in_type, INVALID);
        chk("hr_loaded_kept", key_loaded, 1'b1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            if (eng_in_type != INVALID || eng_halt) bad++;
        end
        chk("hr_quiet_after", bad, 0);

        // Halt during KEYWAIT returns to IDLE
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 128'h33;
        @(negedge clk) key_valid = 1'b0;
        wait_setkey("hk_setkey_seen");
        repeat (3) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        #2 chk("hk_halt_pulse", eng_halt, 1'b1);
        chk("hk_loaded", key_loaded, 1'b0);
        chk("hk_idle_ready", key_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #2;
            if (eng_set_key || key_loaded) bad++;
        end
        chk("hk_stays_idle", bad, 0);

        // Back-pressure in IDLE: INVALID dropped, 4 fill, 5th stalls
        @(negedge clk);
        job_valid = 1'b1;
        job_type = INVALID;
        job_data = 128'hff;
        @(negedge clk);
        #2 chk("bp_invalid_dropped", fifo_count, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            job_type = (k % 2 == 0) ? ENCRYPT : DECRYPT;
            job_data = 128'hc0 + 128'(k);
        end
        @(negedge clk);
        job_type = ENCRYPT;
        job_data = 128'hc4;
        #2 chk("bp_ready_low", job_ready, 1'b0);
        chk("bp_count_full", fifo_count, 4);
        bad = 0;
        repeat (3) begin
            @(negedge clk); #2;
            if (job_ready) bad++;
        end
        chk("bp_stall", bad, 0);
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 128'h44;
        drop = 1'b0;
        ic.delete(); it.delete(); id.delete();
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (drop) job_valid = 1'b0;
            #2;
            if (job_valid && job_ready) drop = 1'b1;
            if (eng_in_type != INVALID) begin
                ic.push_back(i); it.push_back(eng_in_type);
                id.push_back(eng_state);
            end
        end
        chk("bp_issues", ic.size(), 5);
        if (ic.size() == 5) begin
            chk("bp_first_at", ic[0], 13);
            chk("bp_last_at", ic[4], 17);
            chk("bp_type1", it[1], DECRYPT);
            chk("bp_data0", id[0], 128'hc0);
            chk("bp_data3", id[3], 128'hc3);
            chk("bp_data4", id[4], 128'hc4);
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 128'h55;
        @(negedge clk);
        key_valid = 1'b0;
        job_valid = 1'b1;
        job_type = DECRYPT;
        job_data = 128'hd0;
        @(negedge clk) job_data = 128'hd1;
        @(negedge clk) job_valid = 1'b0;
        wait_setkey("rs_setkey_seen");
        wait_loaded("rs_loaded_seen");
        chk("rs_count_before", fifo_count, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_in_type", eng_in_type, INVALID);
        chk("rs_state", eng_state, 0);
        chk("rs_key", eng_key, 0);
        chk("rs_count", fifo_count, 0);
        chk("rs_loaded", key_loaded, 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (eng_in_type != INVALID || key_loaded) bad++;
        end
        chk("rs_no_issue", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
